mem_stage_ctrl: RTL and testbench

Memory-stage controller of the five-stage pipeline: consumes the EX/MEM pipeline register outputs, runs the data-memory request/acknowledge handshake, and resolves branches. It also holds the MEM/WB pipeline register that feeds write-back. While a memory access is outstanding it asserts `stall` to freeze PC, IF/ID, ID/EX and EX/MEM, and inserts bubbles into MEM/WB so that each instruction writes back exactly once.

---
 rtl/mem_stage_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: dmem handshake, branch resolve, MEM/WB register
module mem_stage_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_memtoreg,
   input  logic        MEM_regwrite,
   input  logic        MEM_memread,
   input  logic        MEM_memwrite,
   input  logic        MEM_branch,
   input  logic [31:0] MEM_branch_PC,
   input  logic        MEM_zero,
   input  logic [31:0] MEM_aluresult,
   input  logic [31:0] MEM_readda2,
   input  logic [4:0]  MEM_writereg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        PCSrc,
   output logic [31:0] branch_target,
   output logic        WB_memtoreg,
   output logic        WB_regwrite,
   output logic [31:0] WB_readdata,
   output logic [31:0] WB_aluresult,
   output logic [4:0]  WB_writereg,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt, cnt_next;

   logic access;
   logic aligned;
   logic misalign;
   logic abort;

   logic        wb_memtoreg_n;
   logic        wb_regwrite_n;
   logic [31:0] wb_readdata_n;
   logic [31:0] wb_aluresult_n;
   logic [4:0]  wb_writereg_n;

   assign access  = MEM_memread | MEM_memwrite;
   assign aligned = (MEM_aluresult[1:0] == 2'b00);

   // Address/data go straight through; write enable is only meaningful while requesting.
   assign dmem_addr     = MEM_aluresult;
   assign dmem_wdata    = MEM_readda2;
   assign dmem_we       = dmem_req & MEM_memwrite;

   // Branch resolution is independent of the memory handshake.
   assign PCSrc         = MEM_branch & MEM_zero;
   assign branch_target = MEM_branch_PC;

   // Next state, stall and the value MEM/WB captures this cycle (bubble by default).
   always_comb begin
      next_state     = state;
      cnt_next       = cnt;
      stall          = 1'b0;
      misalign       = 1'b0;
      abort          = 1'b0;
      wb_memtoreg_n  = 1'b0;
      wb_regwrite_n  = 1'b0;
      wb_readdata_n  = 32'h0;
      wb_aluresult_n = 32'h0;
      wb_writereg_n  = 5'h0;
      case (state)
         IDLE: begin
            if (access && aligned) begin
               stall      = 1'b1;
               next_state = ACCESS;
               cnt_next   = '0;
            end else if (access) begin
               // Misaligned: retire without a register write, flag it next cycle.
               misalign       = 1'b1;
               wb_aluresult_n = MEM_aluresult;
               wb_writereg_n  = MEM_writereg;
            end else begin
               wb_memtoreg_n  = MEM_memtoreg;
               wb_regwrite_n  = MEM_regwrite;
               wb_aluresult_n = MEM_aluresult;
               wb_writereg_n  = MEM_writereg;
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               // A combined read+write is treated as a write, so nothing loads from memory.
               next_state     = IDLE;
               wb_memtoreg_n  = MEM_memtoreg & ~MEM_memwrite;
               wb_regwrite_n  = MEM_regwrite;
               wb_readdata_n  = dmem_rdata;
               wb_aluresult_n = MEM_aluresult;
               wb_writereg_n  = MEM_writereg;
            end else if (cnt == CNT_LAST) begin
               next_state     = IDLE;
               abort          = 1'b1;
               wb_aluresult_n = MEM_aluresult;
               wb_writereg_n  = MEM_writereg;
            end else begin
               stall    = 1'b1;
               cnt_next = cnt + 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, counter, registered request, MEM/WB register and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         dmem_req     <= 1'b0;
         WB_memtoreg  <= 1'b0;
         WB_regwrite  <= 1'b0;
         WB_readdata  <= 32'h0;
         WB_aluresult <= 32'h0;
         WB_writereg  <= 5'h0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         state        <= next_state;
         cnt          <= cnt_next;
         dmem_req     <= (next_state == ACCESS);
         WB_memtoreg  <= wb_memtoreg_n;
         WB_regwrite  <= wb_regwrite_n;
         WB_readdata  <= wb_readdata_n;
         WB_aluresult <= wb_aluresult_n;
         WB_writereg  <= wb_writereg_n;
         misalign_err <= misalign;
         bus_err      <= abort;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite, MEM_branch;
   logic [31:0] MEM_branch_PC;
   logic        MEM_zero;
   logic [31:0] MEM_aluresult, MEM_readda2;
   logic [4:0]  MEM_writereg;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall, PCSrc;
   logic [31:0] branch_target;
   logic        WB_memtoreg, WB_regwrite;
   logic [31:0] WB_readdata, WB_aluresult;
   logic [4:0]  WB_writereg;
   logic        misalign_err, bus_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        memtoreg, regwrite, memread, memwrite, branch, zero;
      logic [31:0] bpc, alu, rd2;
      logic [4:0]  wr;
   } instr_t;

   mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .MEM_memtoreg(MEM_memtoreg), .MEM_regwrite(MEM_regwrite),
      .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
      .MEM_branch(MEM_branch), .MEM_branch_PC(MEM_branch_PC),
      .MEM_zero(MEM_zero), .MEM_aluresult(MEM_aluresult),
      .MEM_readda2(MEM_readda2), .MEM_writereg(MEM_writereg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
      .WB_memtoreg(WB_memtoreg), .WB_regwrite(WB_regwrite),
      .WB_readdata(WB_readdata), .WB_aluresult(WB_aluresult),
      .WB_writereg(WB_writereg), .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_wb(input logic m2r, input logic rw, input logic [31:0] rd,
                           input logic [31:0] alu, input logic [4:0] wr);
      check("wb_memtoreg", 32'(WB_memtoreg), 32'(m2r));
      check("wb_regwrite", 32'(WB_regwrite), 32'(rw));
      check("wb_readdata", WB_readdata, rd);
      check("wb_aluresult", WB_aluresult, alu);
      check("wb_writereg", 32'(WB_writereg), 32'(wr));
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 branch, 4 load+store
   function automatic instr_t mk(input int kind, input logic [31:0] alu, input logic [31:0] rd2,
                                 input logic [4:0] wr, input logic zero, input logic [31:0] bpc);
      instr_t i;
      i.memtoreg = (kind == 1 || kind == 4);
      i.regwrite = (kind == 0 || kind == 1 || kind == 4);
      i.memread  = (kind == 1 || kind == 4);
      i.memwrite = (kind == 2 || kind == 4);
      i.branch   = (kind == 3);
      i.zero = zero; i.bpc = bpc; i.alu = alu; i.rd2 = rd2; i.wr = wr;
      return i;
   endfunction

   // Present one instruction in MEM and follow it until it retires.
   // k = ack latency in request cycles (0 = never acked); spur = ack driven while no access.
   task automatic run(input instr_t in, input int k, input logic [31:0] rdata, input logic spur);
      logic acc, al, done;
      MEM_memtoreg = in.memtoreg; MEM_regwrite = in.regwrite;
      MEM_memread = in.memread; MEM_memwrite = in.memwrite;
      MEM_branch = in.branch; MEM_zero = in.zero; MEM_branch_PC = in.bpc;
      MEM_aluresult = in.alu; MEM_readda2 = in.rd2; MEM_writereg = in.wr;
      acc = in.memread | in.memwrite;
      al  = (in.alu[1:0] == 2'b00);
      dmem_rdata = rdata;
      if (!(acc && al)) begin
         dmem_ack = spur;
         #1;
         check("stall_free", 32'(stall), 32'd0);
         check("req_idle", 32'(dmem_req), 32'd0);
         check("pcsrc", 32'(PCSrc), 32'(in.branch & in.zero));
         check("branch_target", branch_target, in.bpc);
         @(posedge clk); @(negedge clk);
         dmem_ack = 1'b0;
         if (acc) check_wb(1'b0, 1'b0, 32'h0, in.alu, in.wr);
         else     check_wb(in.memtoreg, in.regwrite, 32'h0, in.alu, in.wr);
         check("misalign_err", 32'(misalign_err), 32'(acc));
         check("bus_err_idle", 32'(bus_err), 32'd0);
         check("req_after_idle", 32'(dmem_req), 32'd0);
      end else begin
         dmem_ack = 1'b0;
         #1;
         check("stall_first", 32'(stall), 32'd1);
         check("req_first", 32'(dmem_req), 32'd0);
         check("pcsrc_mem", 32'(PCSrc), 32'd0);
         done = 1'b0;
         for (int c = 1; c <= TIMEOUT && !done; c++) begin
            @(posedge clk); @(negedge clk);
            check_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
            check("req_access", 32'(dmem_req), 32'd1);
            check("we_access", 32'(dmem_we), 32'(in.memwrite));
            check("dmem_addr", dmem_addr, in.alu);
            check("dmem_wdata", dmem_wdata, in.rd2);
            check("misalign_access", 32'(misalign_err), 32'd0);
            check("bus_err_access", 32'(bus_err), 32'd0);
            if (c == k) begin
               dmem_ack = 1'b1;
               #1;
               check("stall_ack", 32'(stall), 32'd0);
               @(posedge clk); @(negedge clk);
               dmem_ack = 1'b0;
               check_wb(in.memtoreg & ~in.memwrite, in.regwrite, rdata, in.alu, in.wr);
               check("bus_err_ok", 32'(bus_err), 32'd0);
               done = 1'b1;
            end else if (c == TIMEOUT) begin
               #1;
               check("stall_abort", 32'(stall), 32'd0);
               @(posedge clk); @(negedge clk);
               check_wb(1'b0, 1'b0, 32'h0, in.alu, in.wr);
               check("bus_err_pulse", 32'(bus_err), 32'd1);
               done = 1'b1;
            end else begin
               #1;
               check("stall_wait", 32'(stall), 32'd1);
            end
         end
         check("req_released", 32'(dmem_req), 32'd0);
         check("we_released", 32'(dmem_we), 32'd0);
         check("misalign_after", 32'(misalign_err), 32'd0);
      end
   endtask

   initial begin
      instr_t ins;
      int kind, k;
      logic [31:0] a;
      rst = 1'b1;
      MEM_memtoreg = 0; MEM_regwrite = 0; MEM_memread = 0; MEM_memwrite = 0;
      MEM_branch = 0; MEM_zero = 0; MEM_branch_PC = 0; MEM_aluresult = 0;
      MEM_readda2 = 0; MEM_writereg = 0; dmem_ack = 0; dmem_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
      rst = 1'b0;

      run(mk(1, 32'h10, 32'h0, 5'd7, 1'b0, 32'h0), 3, 32'hDEADBEEF, 1'b0);
      run(mk(2, 32'h20, 32'h12345678, 5'd0, 1'b0, 32'h0), 1, 32'h0BADF00D, 1'b0);
      run(mk(0, 32'hCAFE0001, 32'h0, 5'd9, 1'b0, 32'h0), 0, 32'h0, 1'b0);
      run(mk(1, 32'h44, 32'h0, 5'd3, 1'b0, 32'h0), 2, 32'hA5A5A5A5, 1'b0);
      run(mk(1, 32'h13, 32'h0, 5'd4, 1'b0, 32'h0), 0, 32'h0, 1'b0);
      run(mk(1, 32'h80, 32'h0, 5'd5, 1'b0, 32'h0), 0, 32'h0, 1'b0);
      run(mk(0, 32'h1234, 32'h0, 5'd6, 1'b0, 32'h0), 0, 32'hFFFFFFFF, 1'b1);
      run(mk(3, 32'h0, 32'h0, 5'd0, 1'b1, 32'h400), 0, 32'h0, 1'b0);
      run(mk(3, 32'h1, 32'h0, 5'd0, 1'b0, 32'h400), 0, 32'h0, 1'b0);
      run(mk(4, 32'h100, 32'h55AA55AA, 5'd8, 1'b0, 32'h0), TIMEOUT, 32'h77777777, 1'b0);

      // Reset in the middle of an access abandons it; a late ack is ignored.
      ins = mk(1, 32'h200, 32'h0, 5'd11, 1'b0, 32'h0);
      MEM_memtoreg = ins.memtoreg; MEM_regwrite = ins.regwrite;
      MEM_memread = ins.memread; MEM_memwrite = ins.memwrite;
      MEM_branch = 0; MEM_aluresult = ins.alu; MEM_writereg = ins.wr;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_rst_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midrst_req", 32'(dmem_req), 32'd0);
      check("midrst_misalign", 32'(misalign_err), 32'd0);
      check("midrst_bus_err", 32'(bus_err), 32'd0);
      check_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
      rst = 1'b0;
      run(mk(0, 32'h3000, 32'h0, 5'd12, 1'b0, 32'h0), 0, 32'h13572468, 1'b1);

      for (int n = 0; n < 80; n++) begin
         kind = int'($urandom_range(0, 4));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         k = int'($urandom_range(0, TIMEOUT));
         ins = mk(kind, a, $urandom, 5'($urandom), 1'($urandom), $urandom);
         run(ins, k, $urandom, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
